// File: rtl/fifo_serial_tx_if.sv
// FIFO read-port bundle between a first-word-fall-through FIFO and its consumer.
//   fifoEmpty  FIFO empty flag (driven by the FIFO)
//   fifoDout   head word, valid while fifoEmpty=0 (driven by the FIFO)
//   fifoRen    pop strobe, one cycle per word (driven by the consumer)
// Modports: master = consumer (fifo_serial_tx), slave = FIFO side.
interface fifo_serial_tx_if #(
  parameter int unsigned BITWIDTH = 5
) ();
  logic                fifoEmpty;
  logic [BITWIDTH-1:0] fifoDout;
  logic                fifoRen;

  modport master (
    input  fifoEmpty,
    input  fifoDout,
    output fifoRen
  );

  modport slave (
    output fifoEmpty,
    output fifoDout,
    input  fifoRen
  );
endinterface

// File: rtl/fifo_serial_tx.sv
// Serial transmitter fed from a first-word-fall-through FIFO. Pops one word per frame and sends
// it LSB-first: start bit (0), BITWIDTH data bits, optional even-parity bit, stop bit (1). Each
// bit lasts CLKS_PER_BIT clocks. Back-to-back frames have no idle gap between stop and start.
// Optional feature: define SERIAL_TX_PARITY_EN to insert the even-parity bit before the stop bit.
// Ports:
//   clk       clock, all logic on posedge
//   rst       synchronous active-high reset; aborts any frame in progress
//   txEn      1 = may start new frames; 0 = finish current frame, then idle
//   fifo      FIFO read port (master modport): fifoEmpty, fifoDout in, fifoRen out (combinational)
//   txd       serial line, idle high, registered
//   busy      1 while a frame is on the line, registered
//   frameCnt  frames completed since reset, wraps
module fifo_serial_tx #(
  parameter int unsigned BITWIDTH     = 5,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 txEn,
  fifo_serial_tx_if.master     fifo,
  output logic                 txd,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] frameCnt
);

  localparam int unsigned TickW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef SERIAL_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e              state_q;
  logic [BITWIDTH-1:0] shift_q;
  logic [TickW-1:0]    tick_q;
  logic [BitW-1:0]     bit_q;
`ifdef SERIAL_TX_PARITY_EN
  logic                parity_q;
`endif

  logic                last_tick;
  logic                last_bit;
  logic                pop_now;
  logic [BITWIDTH-1:0] shifted;

  assign last_tick = (tick_q == TickW'(CLKS_PER_BIT - 1));
  assign last_bit  = (bit_q == BitW'(BITWIDTH - 1));
  assign shifted   = shift_q >> 1;

  // A new word is taken only when the line is free now or at the end of the current stop bit.
  assign pop_now = !rst && txEn && !fifo.fifoEmpty &&
                   ((state_q == StIdle) || ((state_q == StStop) && last_tick));

  assign fifo.fifoRen = pop_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      tick_q   <= '0;
      bit_q    <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      frameCnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (pop_now) begin
      // Latch the word now; an emptying FIFO cannot disturb the frame afterwards.
      if (state_q == StStop) begin
        frameCnt <= frameCnt + CNT_WIDTH'(1);
      end
      state_q  <= StStart;
      shift_q  <= fifo.fifoDout;
      tick_q   <= '0;
      bit_q    <= '0;
      txd      <= 1'b0;
      busy     <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= ^fifo.fifoDout;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          txd  <= 1'b1;
          busy <= 1'b0;
        end
        StStart: begin
          if (last_tick) begin
            tick_q  <= '0;
            state_q <= StData;
            txd     <= shift_q[0];
          end else begin
            tick_q <= tick_q + TickW'(1);
          end
        end
        StData: begin
          if (last_tick) begin
            tick_q <= '0;
            if (last_bit) begin
              bit_q <= '0;
`ifdef SERIAL_TX_PARITY_EN
              state_q <= StParity;
              txd     <= parity_q;
`else
              state_q <= StStop;
              txd     <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + BitW'(1);
              shift_q <= shifted;
              txd     <= shifted[0];
            end
          end else begin
            tick_q <= tick_q + TickW'(1);
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        StParity: begin
          if (last_tick) begin
            tick_q  <= '0;
            state_q <= StStop;
            txd     <= 1'b1;
          end else begin
            tick_q <= tick_q + TickW'(1);
          end
        end
`endif
        StStop: begin
          if (last_tick) begin
            // No follow-on word: count the frame and return to idle.
            tick_q   <= '0;
            frameCnt <= frameCnt + CNT_WIDTH'(1);
            state_q  <= StIdle;
            busy     <= 1'b0;
            txd      <= 1'b1;
          end else begin
            tick_q <= tick_q + TickW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          tick_q  <= '0;
          bit_q   <= '0;
          txd     <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: a queue-based FIFO feeds the DUT, and a line model expands every
// popped word into its expected per-cycle txd samples (start, data LSB-first, parity, stop).
module tb_fifo_serial_tx;
  localparam int unsigned BW  = 5;
  localparam int unsigned CPB = 4;
  localparam int unsigned CW  = 16;

  typedef struct packed {
    logic last;
    logic b;
  } samp_t;

  logic          clk;
  logic          rst;
  logic          txEn;
  logic          txd;
  logic          busy;
  logic [CW-1:0] frameCnt;

  fifo_serial_tx_if #(.BITWIDTH(BW)) fif ();

  fifo_serial_tx #(
    .BITWIDTH    (BW),
    .CLKS_PER_BIT(CPB),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .txEn    (txEn),
    .fifo    (fif),
    .txd     (txd),
    .busy    (busy),
    .frameCnt(frameCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   n_cmp;
  int unsigned   n_bad;
  logic [BW-1:0] fifo_q[$];
  samp_t         line_q[$];
  logic [CW-1:0] cnt_exp;
  logic          pend_pop;
  logic          pend_rst;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic push_bits(input logic v, input logic last);
    samp_t s;
    for (int i = 0; i < int'(CPB); i++) begin
      s.b    = v;
      s.last = last && (i == int'(CPB) - 1);
      line_q.push_back(s);
    end
  endtask

  task automatic add_frame(input logic [BW-1:0] w);
    push_bits(1'b0, 1'b0);
    for (int i = 0; i < int'(BW); i++) push_bits(w[i], 1'b0);
`ifdef SERIAL_TX_PARITY_EN
    push_bits(^w, 1'b0);
`endif
    push_bits(1'b1, 1'b1);
  endtask

  // One clock: check this cycle's outputs, apply inputs, check the pop strobe.
  task automatic step(input logic r, input logic en);
    samp_t         s;
    logic          exp_txd;
    logic          exp_busy;
    logic          is_last;
    logic          exp_ren;
    logic [BW-1:0] w;
    @(negedge clk);
    if (pend_rst) begin
      line_q.delete();
      cnt_exp = '0;
    end else if (pend_pop) begin
      w = fifo_q.pop_front();
      add_frame(w);
    end
    if (line_q.size() > 0) begin
      s        = line_q.pop_front();
      exp_txd  = s.b;
      exp_busy = 1'b1;
      is_last  = s.last;
    end else begin
      exp_txd  = 1'b1;
      exp_busy = 1'b0;
      is_last  = 1'b0;
    end
    check_eq("txd", 32'(txd), 32'(exp_txd));
    check_eq("busy", 32'(busy), 32'(exp_busy));
    check_eq("frameCnt", 32'(frameCnt), 32'(cnt_exp));
    if (is_last) cnt_exp = cnt_exp + 1'b1;
    rst           = r;
    txEn          = en;
    fif.fifoEmpty = (fifo_q.size() == 0);
    fif.fifoDout  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    #1;
    exp_ren = !r && en && (fifo_q.size() > 0) && (line_q.size() == 0);
    check_eq("fifoRen", 32'(fif.fifoRen), 32'(exp_ren));
    pend_pop = exp_ren;
    pend_rst = r;
  endtask

  task automatic run(input int n, input logic en);
    for (int i = 0; i < n; i++) step(1'b0, en);
  endtask

  logic en_r;

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    cnt_exp       = '0;
    pend_pop      = 1'b0;
    pend_rst      = 1'b1;
    rst           = 1'b1;
    txEn          = 1'b0;
    fif.fifoEmpty = 1'b1;
    fif.fifoDout  = '0;

    // Reset, then idle with an empty FIFO.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    run(20, 1'b1);

    // Reset in the middle of data bit 2 (frameCnt still 0 here).
    fifo_q.push_back(5'b10110);
    run(1 + int'(CPB) + 2 * int'(CPB) + 1, 1'b1);
    step(1'b1, 1'b1);
    run(10, 1'b1);

    // Single frame.
    fifo_q.push_back(5'b10110);
    run(40, 1'b1);

    // Three frames back-to-back.
    fifo_q.push_back(5'h1F);
    fifo_q.push_back(5'h00);
    fifo_q.push_back(5'h15);
    run(3 * int'((BW + 3) * CPB) + 10, 1'b1);

    // txEn dropped after the first start bit with two words queued.
    fifo_q.push_back(5'h0A);
    fifo_q.push_back(5'h13);
    run(1 + int'(CPB), 1'b1);
    run(60, 1'b0);
    run(50, 1'b1);

    // Randomized traffic with random enable runs.
    en_r = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 8 && fifo_q.size() < 6) fifo_q.push_back(BW'($urandom));
      if ($urandom_range(0, 99) < 2) en_r = !en_r;
      step(1'b0, en_r);
    end
    run(200, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
